// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width, a count type
// wide enough for the largest legal counter, and binary/Gray conversions.
package gray_pkg;

    localparam int DEFAULT_SIZE = 4;
    localparam int MAX_SIZE     = 16;

    // Count type sized for the widest legal counter; narrower counters use
    // the low SIZE bits and leave the upper bits zero.
    typedef logic [MAX_SIZE-1:0] count_t;

    // Binary to reflected-binary Gray code.
    function automatic count_t bin2gray(input count_t b);
        return b ^ (b >> 1);
    endfunction

    // Reflected-binary Gray code back to binary (prefix XOR from the MSB).
    function automatic count_t gray2bin(input count_t g);
        count_t b;
        b[MAX_SIZE-1] = g[MAX_SIZE-1];
        for (int i = MAX_SIZE - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-Gray encoder used on the counter's next-state value.
module bin2gray_enc
    import gray_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic [SIZE-1:0] bin,
    output logic [SIZE-1:0] gray
);

    // The MSB passes straight through; every lower bit is the XOR of itself
    // and its upper neighbour.
    assign gray[SIZE-1] = bin[SIZE-1];

    generate
        for (genvar gi = 0; gi < SIZE - 1; gi++) begin : g_bit
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-code output, wrap pulse and
// optional saturation. Define GRAY_COUNTER_SAT_EN to make the counter hold
// at its extremes (sat_o high) instead of wrapping.
module gray_counter
    import gray_pkg::*;
#(
    parameter int SIZE      = DEFAULT_SIZE,
    parameter int RESET_BIN = 0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            inc_i,
    input  logic            dir_i,
    input  logic            load_i,
    input  logic [SIZE-1:0] load_bin_i,
    output logic [SIZE-1:0] bin_o,
    output logic [SIZE-1:0] gray_o,
    output logic            wrap_o,
    output logic            sat_o
);

    localparam count_t          RESET_BIN_FULL  = count_t'(RESET_BIN);
    localparam count_t          RESET_GRAY_FULL = bin2gray(RESET_BIN_FULL);
    localparam logic [SIZE-1:0] RESET_BIN_VAL   = RESET_BIN_FULL[SIZE-1:0];
    localparam logic [SIZE-1:0] RESET_GRAY_VAL  = RESET_GRAY_FULL[SIZE-1:0];
    localparam logic [SIZE-1:0] MAX_BIN         = '1;
    localparam logic [SIZE-1:0] ONE             = SIZE'(1);

    logic [SIZE-1:0] bin_reg;
    logic [SIZE-1:0] gray_reg;
    logic            wrap_reg;
    logic            sat_reg;

    logic [SIZE-1:0] bin_next;
    logic [SIZE-1:0] gray_next;
    logic            wrap_next;
    logic            sat_next;
    logic            at_max;
    logic            at_min;

    assign at_max = (bin_reg == MAX_BIN);
    assign at_min = (bin_reg == '0);

    // Next-state selection: load beats a step, up beats down, otherwise hold.
    always_comb begin
        bin_next  = bin_reg;
        wrap_next = 1'b0;
`ifdef GRAY_COUNTER_SAT_EN
        sat_next  = sat_reg;
`else
        sat_next  = 1'b0;
`endif
        if (load_i) begin
            // A load never reports a wrap, whatever value it lands on.
            bin_next = load_bin_i;
            sat_next = 1'b0;
        end else if (inc_i && dir_i) begin
`ifdef GRAY_COUNTER_SAT_EN
            if (at_max) begin
                sat_next = 1'b1;
            end else begin
                bin_next = bin_reg + ONE;
                sat_next = 1'b0;
            end
`else
            bin_next  = bin_reg + ONE;
            wrap_next = at_max;
`endif
        end else if (inc_i) begin
`ifdef GRAY_COUNTER_SAT_EN
            if (at_min) begin
                sat_next = 1'b1;
            end else begin
                bin_next = bin_reg - ONE;
                sat_next = 1'b0;
            end
`else
            bin_next  = bin_reg - ONE;
            wrap_next = at_min;
`endif
        end
    end

    // Gray value is derived from the next binary value so both registers
    // update together and the Gray output only ever moves by one bit.
    bin2gray_enc #(
        .SIZE(SIZE)
    ) u_enc (
        .bin  (bin_next),
        .gray (gray_next)
    );

    // All counter state, cleared asynchronously to the reset values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bin_reg  <= RESET_BIN_VAL;
            gray_reg <= RESET_GRAY_VAL;
            wrap_reg <= 1'b0;
            sat_reg  <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            wrap_reg <= wrap_next;
            sat_reg  <= sat_next;
        end
    end

    assign bin_o  = bin_reg;
    assign gray_o = gray_reg;
    assign wrap_o = wrap_reg;
    assign sat_o  = sat_reg;

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter SIZE, default 4: counter width in bits, legal range 2..16.
REQ-002 SHALL have parameter RESET_BIN, default 0: binary value loaded at reset, legal range 0..2^SIZE-1.
REQ-003 SHALL have port clk_i  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inc_i  input  1  step request; the counter steps once per cycle while this port is high.
REQ-006 SHALL have port dir_i  input  1  step direction: 1 = up, 0 = down.
REQ-007 SHALL have port load_i  input  1  synchronous load strobe.
REQ-008 SHALL have port load_bin_i  input  SIZE  binary value applied on load.
REQ-009 SHALL have port bin_o  output  SIZE  registered binary count.
REQ-010 SHALL have port gray_o  output  SIZE  registered Gray encoding of bin_o, glitch-free, safe to synchronise across clock domains.
REQ-011 SHALL have port wrap_o  output  1  registered one-cycle pulse on wrap-around.
REQ-012 SHALL have port sat_o  output  1  registered level, high while the counter is saturated.

Function
REQ-013 SHALL compute next_bin each cycle with the following priority: load_i -> load_bin_i; else inc_i&dir_i -> bin+1; else inc_i&!dir_i -> bin-1; else hold.
REQ-014 SHALL register bin_o and gray_o on the same clock edge, with gray_o = next_bin ^ (next_bin>>1) computed from next_bin, never from bin_o.
REQ-015 SHALL give 1-cycle latency from a sampled input to updated outputs, with no combinational path from any input to any output.
REQ-016 SHALL guarantee that any inc step changes exactly one bit of gray_o, including across the wrap point.
REQ-017 SHALL, without saturation: count up from 2^SIZE-1 to 0 and pulse wrap_o for one cycle; count down from 0 to 2^SIZE-1 and pulse wrap_o for one cycle.
REQ-018 SHALL keep wrap_o low on a load, even if the loaded value crosses a boundary.
REQ-019 SHALL, on simultaneous load_i and inc_i, perform the load only; the step is discarded.
REQ-020 SHALL treat dir_i as a don't-care when inc_i=0 and load_i=0; outputs hold.

Reset
REQ-021 SHALL, on rst_n_i low, immediately force bin_o=RESET_BIN, gray_o=RESET_BIN^(RESET_BIN>>1), wrap_o=0 and sat_o=0.
REQ-022 SHALL hold the reset values while rst_n_i is low, and on the first rising clk_i edge after deassertion evaluate inputs normally.
REQ-023 SHALL abandon any pending step or load when reset is asserted mid-operation; no wrap_o pulse is generated.

Configuration
REQ-024 SHALL define macro GRAY_COUNTER_SAT_EN: when defined, stepping up at 2^SIZE-1 or down at 0 holds the value, sat_o=1 and wrap_o stays 0.
REQ-025 SHALL, with GRAY_COUNTER_SAT_EN defined, clear sat_o on the first cycle the value leaves the extreme, by a step in the opposite direction or by a load.
REQ-026 SHALL, with GRAY_COUNTER_SAT_EN undefined, use wrap behaviour per REQ-017 and tie sat_o constant 0.

Structure
REQ-027 SHALL place in shared package gray_pkg: the default SIZE constant, a parameterised count typedef, and bin2gray/gray2bin functions.
REQ-028 SHALL instantiate one sub-module, bin2gray_enc (combinational, parameter SIZE), for the next-state encoding.
REQ-029 SHALL contain all state in one always_ff block: registers bin, gray, wrap and sat.

Verification (SIZE=4, RESET_BIN=0)
REQ-030 SHALL check reset: assert rst_n_i mid-count at bin=5 -> outputs immediately bin_o=0000, gray_o=0000, wrap_o=0, sat_o=0, with no clock edge needed.
REQ-031 SHALL check the up sequence: inc_i=1, dir_i=1 for 16 cycles -> gray_o = 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; exactly one bit changes per step; wrap_o pulses only on the 1000->0000 step.
REQ-032 SHALL check the down wrap: from 0, inc_i=1, dir_i=0 -> bin_o=1111, gray_o=1000, wrap_o=1 for one cycle; next step -> bin_o=1110, gray_o=1001, wrap_o=0.
REQ-033 SHALL check load priority: load_i=1, load_bin_i=0110, inc_i=1 in the same cycle -> bin_o=0110, gray_o=0101, wrap_o=0.
REQ-034 SHALL check saturation with GRAY_COUNTER_SAT_EN defined: load 1111, then 3 up-steps -> bin_o stays 1111, gray_o stays 1000, sat_o=1, wrap_o=0; one down-step -> bin_o=1110, sat_o=0.
REQ-035 SHALL check hold: inc_i=0, load_i=0 while dir_i toggles randomly for 20 cycles -> bin_o and gray_o unchanged.
